// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared frame-buffer constants and the writer FSM state type. The VGA read
// side imports the same image geometry so both ends agree on the buffer map.
//
// Configuration macro: FB_CLEAR_EN -- when defined, the writer gains a CLEAR
// state that zero-fills the buffer before accepting pixel data.
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int IMG_W      = 100;
  localparam int IMG_H      = 100;
  localparam int NUM_PIXELS = IMG_W * IMG_H;  // 8-bit grayscale, row-major
  localparam int ADDR_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
`ifdef FB_CLEAR_EN
    ST_CLEAR    = 3'd1,
`endif
    ST_ACCEPT   = 3'd2,
    ST_WRITE_LO = 3'd3,
    ST_DONE     = 3'd4
  } fb_state_e;

endpackage

// File: rtl/frame_buffer_writer.sv
// ---------------------------------------------------------------------------
// frame_buffer_writer
// Unpacks 16-bit decrypted words (two pixels each) into byte writes to a
// frame buffer, one frame per start pulse. The high byte goes to the even
// address, the low byte to the following odd address.
//
// Configuration macro: FB_CLEAR_EN -- when defined, start first zero-fills
// addresses 0..NUM_PIXELS-1 (one per cycle) before accepting data.
//
// Ports
//   clk_25Mhz   in   sole clock, rising edge
//   rst         in   synchronous, active-high reset
//   start       in   one-cycle pulse, begins a frame (ignored while busy)
//   in_valid    in   in_data is valid
//   in_ready    out  word accepted this cycle (decoded: high only in ACCEPT)
//   in_data     in   [15:8] even-address pixel, [7:0] odd-address pixel
//   wr_en       out  frame-buffer write strobe
//   wr_addr     out  write address (holds when wr_en=0)
//   wr_data     out  write data (holds when wr_en=0)
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse after the last pixel is written
// ---------------------------------------------------------------------------
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int NUM_PIXELS = fb_pkg::NUM_PIXELS,  // must be even
  parameter int ADDR_W     = fb_pkg::ADDR_W
) (
  input  logic              clk_25Mhz,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  fb_state_e         r_state;
  logic [ADDR_W-1:0] r_addr;      // even address of the word being unpacked
  logic [7:0]        r_lo_byte;   // low pixel held for the WRITE_LO cycle
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_busy;
  logic              r_frame_done;

  logic [ADDR_W-1:0] w_addr_odd;

  assign w_addr_odd = r_addr + ADDR_W'(1);

  // Ready is decoded straight from the state so an accepted word is seen in
  // the same cycle; every other output is registered.
  assign in_ready   = (r_state == ST_ACCEPT);

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  // NOTE: all state lives in one clocked block written only with <=, so every
  // right-hand side sees the pre-edge value and block order cannot matter.
  always_ff @(posedge clk_25Mhz) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_lo_byte    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_wr_en <= 1'b0;
          // busy is still high for the frame_done cycle, which keeps a start
          // arriving right at the end of a frame from being taken.
          if (start && !r_busy) begin
            r_addr  <= '0;
            r_busy  <= 1'b1;
`ifdef FB_CLEAR_EN
            r_state <= ST_CLEAR;
`else
            r_state <= ST_ACCEPT;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end

`ifdef FB_CLEAR_EN
        ST_CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= '0;
          if (r_addr == LAST_ADDR) begin
            r_addr  <= '0;
            r_state <= ST_ACCEPT;
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
          end
        end
`endif

        ST_ACCEPT: begin
          if (in_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= in_data[15:8];
            r_lo_byte <= in_data[7:0];
            r_state   <= ST_WRITE_LO;
          end else begin
            r_wr_en   <= 1'b0;
          end
        end

        ST_WRITE_LO: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_addr_odd;
          r_wr_data <= r_lo_byte;
          // Stop on the last odd address so the counter never runs into the
          // next frame.
          if (w_addr_odd == LAST_ADDR) begin
            r_state <= ST_DONE;
          end else begin
            r_addr  <= r_addr + ADDR_W'(2);
            r_state <= ST_ACCEPT;
          end
        end

        ST_DONE: begin
          r_wr_en      <= 1'b0;
          r_frame_done <= 1'b1;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_wr_en <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_writer
// Scoreboard bench: each accepted word pushes its two expected byte writes;
// every observed write pops and compares. Frames: streaming, random valid
// with start pokes, reset mid-frame, and a final frame ending in 0xABCD.
// Works with or without FB_CLEAR_EN defined.
// ---------------------------------------------------------------------------
module tb_frame_buffer_writer;

  localparam int NP = fb_pkg::NUM_PIXELS;
  localparam int AW = fb_pkg::ADDR_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_done;

  frame_buffer_writer #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
    .clk_25Mhz (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #20 clk = ~clk;  // 25 MHz

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    bit            is_clear;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            first_hs_cyc = 0;
  bit            seen_hs = 0;
  bit            prev_hs = 0;
  bit            lat_checked = 0;
  bit            mon_en = 0;
  bit            check_timing = 0;
  bit            abcd_mode = 0;
  bit            done_prev = 0;
  int            done_count = 0;
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    last_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Input side: sample the handshake with pre-edge values, queue the writes.
  always @(posedge clk) begin : sb_in
    bit hs;
    hs = in_valid && in_ready && !rst;
    if (rst) begin
      exp_q.delete();
      last_addr = '0;
      last_data = '0;
    end else if (hs) begin
      if (!seen_hs) begin
        seen_hs      = 1;
        first_hs_cyc = cyc;
      end
      exp_q.push_back('{exp_addr, in_data[15:8], 1'b0});
      exp_q.push_back('{AW'(exp_addr + 1), in_data[7:0], 1'b0});
      exp_addr = AW'(exp_addr + 2);
    end
    prev_hs = hs;
    cyc++;
  end

  // Output side: compare away from the active edge.
  always @(negedge clk) begin : sb_out
    exp_t e;
    if (mon_en) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("write_without_handshake", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
          if (e.is_clear && exp_q.size() > 0 && exp_q[0].is_clear)
            check("in_ready_during_clear", in_ready, 0);
          if (!e.is_clear && !lat_checked) begin
            check("first_write_latency", cyc - first_hs_cyc, 1);
            lat_checked = 1;
          end
          if (abcd_mode && !e.is_clear && wr_addr == AW'(NP - 2))
            check("last_word_hi", wr_data, 8'hAB);
          if (abcd_mode && !e.is_clear && wr_addr == AW'(NP - 1))
            check("last_word_lo", wr_data, 8'hCD);
        end
        last_addr = wr_addr;
        last_data = wr_data;
      end else begin
        check("hold_addr", wr_addr, last_addr);
        check("hold_data", wr_data, last_data);
      end
      if (prev_hs) check("in_ready_in_write_lo", in_ready, 0);
      if (done_prev) check("busy_after_done", busy, 0);
      if (frame_done) begin
        done_count++;
        check("done_queue_empty", exp_q.size(), 0);
        check("done_single_pulse", done_prev, 0);
        if (check_timing) check("done_latency", cyc - first_hs_cyc, NP + 1);
      end
      done_prev = frame_done;
    end
  end

  task automatic begin_frame(input bit timing);
    @(negedge clk);
    start        = 1'b1;
    exp_addr     = '0;
    seen_hs      = 0;
    lat_checked  = 0;
    check_timing = timing;
`ifdef FB_CLEAR_EN
    for (int i = 0; i < NP; i++) exp_q.push_back('{AW'(i), 8'h00, 1'b1});
`endif
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_words(input int n, input int pct, input int poke_at, input bit last_abcd);
    for (int w = 0; w < n; w++) begin
      logic [15:0] d;
      bit          done;
      int          budget;
      d      = (last_abcd && w == n - 1) ? 16'hABCD : 16'(w);
      done   = 0;
      budget = 0;
      while (!done) begin
        @(negedge clk);
        in_data  = d;
        in_valid = ($urandom_range(99) < pct);
        start    = (w == poke_at) && in_ready;
        done     = in_valid && in_ready;
        budget++;
        if (budget > NP + 200) begin
          check("handshake_timeout", in_ready, 1);
          in_valid = 1'b0;
          start    = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic finish_frame(input bit poke_done, input int dc0);
    @(negedge clk);            // WRITE_LO of the last word
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);            // DONE
    start = poke_done;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("frame_done_count", done_count, dc0 + 1);
    check("idle_after_frame", busy, 0);
  endtask

  initial begin
    #(40 * 150000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1;
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready", in_ready, 0);

    // Frame 1: streaming words 0x0000..0x1387, frame_done timing checked.
    dc = done_count;
    begin_frame(1);
    send_words(NP / 2, 100, -1, 0);
    finish_frame(0, dc);

    // Frame 2: random in_valid, start poked during ACCEPT and DONE.
    dc = done_count;
    begin_frame(0);
    send_words(NP / 2, 80, 1234, 0);
    finish_frame(1, dc);

    // Reset after 37 words abandons the frame.
    dc = done_count;
    begin_frame(0);
    send_words(37, 100, -1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wr_en", wr_en, 0);
    check("rst_mid_wr_addr", wr_addr, 0);
    check("rst_mid_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", done_count, dc);

    // Frame 3: restart from address 0, last word 0xABCD.
    dc        = done_count;
    abcd_mode = 1;
    begin_frame(1);
    send_words(NP / 2, 100, -1, 1);
    finish_frame(0, dc);
    abcd_mode = 0;

    check("queue_drained", exp_q.size(), 0);
    check("total_frames", done_count, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
